test_cbfp: RTL and testbench

- Convergent block-floating-point (CBFP) normaliser for the FFT datapath.
- Collects a 64-sample block of signed 23-bit values, delivered as 4 beats of 16 lanes.
- Finds the block's common redundant-sign-bit count, shifts every sample left by it, and emits the top 11 bits as 4 beats of 16 lanes.
- Reports the per-beat sign-bit counts on zero_cnt for downstream exponent tracking.

---
 rtl/test_cbfp.sv | 161 ++++++++++++++++
 tb/tb_test_cbfp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_cbfp.sv
// Convergent block-floating-point normaliser.
// Collects 64-sample blocks as 4 beats of 16 lanes into a ping-pong buffer.
// Each completed block is shifted left by its common redundant-sign-bit count
// and emitted as the top dout_size bits of every sample.
module test_cbfp #(
    parameter int cnt_size     = 5,
    parameter int array_size   = 16,
    parameter int din_size     = 23,
    parameter int dout_size    = 11,
    parameter int buffer_depth = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        valid_in,
    input  logic signed [din_size-1:0]  din_re_p  [array_size],
    output logic signed [dout_size-1:0] dout_re_p [array_size],
    output logic                        valid_out,
    output logic [cnt_size-1:0]         zero_cnt  [buffer_depth/array_size]
);

    localparam int BEATS = buffer_depth / array_size;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DROP  = din_size - dout_size;

    typedef logic [cnt_size-1:0]        cnt_t;
    typedef logic signed [din_size-1:0] din_t;

    // Redundant sign bits: run length below the MSB of bits equal to the MSB.
    function automatic cnt_t sign_cnt(input din_t x);
        cnt_t n;
        logic run;
        n   = '0;
        run = 1'b1;
        for (int i = din_size - 2; i >= 0; i--) begin
            if (run && (x[i] == x[din_size-1])) n = n + 1'b1;
            else                                run = 1'b0;
        end
        return n;
    endfunction

    // Write side state
    logic [BW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;

    // Ping-pong sample storage and per-beat counts
    din_t mem_q  [2][BEATS][array_size];
    cnt_t bcnt_q [2][BEATS];

    // Read side state
    logic          rd_active_q, rd_active_d;
    logic [BW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    cnt_t          shift_q, shift_d;

    // Output registers
    logic signed [dout_size-1:0] dout_q [array_size];
    logic signed [dout_size-1:0] dout_d [array_size];
    logic                        valid_q, valid_d;
    cnt_t                        zcnt_q [BEATS];
    cnt_t                        zcnt_d [BEATS];

    cnt_t beat_cnt;
    cnt_t block_min;
    logic last_beat;

    assign last_beat = valid_in && (wr_cnt_q == BW'(BEATS - 1));

    // Beat count: smallest sign-bit count across the incoming lanes
    always_comb begin
        beat_cnt = cnt_t'(din_size - 1);
        for (int l = 0; l < array_size; l++) begin
            if (sign_cnt(din_re_p[l]) < beat_cnt) beat_cnt = sign_cnt(din_re_p[l]);
        end
    end

    // Block shift: earlier stored beats of this block combined with the closing beat
    always_comb begin
        block_min = beat_cnt;
        for (int b = 0; b < BEATS - 1; b++) begin
            if (bcnt_q[wr_bank_q][b] < block_min) block_min = bcnt_q[wr_bank_q][b];
        end
    end

    // Next-state logic for write pointers, read sequencer and output registers
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_active_d = rd_active_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        shift_d     = shift_q;
        valid_d     = 1'b0;
        zcnt_d      = zcnt_q;
        for (int l = 0; l < array_size; l++) dout_d[l] = '0;

        if (valid_in) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (last_beat) wr_bank_d = ~wr_bank_q;
        end

        if (rd_active_q) begin
            valid_d = 1'b1;
            for (int l = 0; l < array_size; l++) begin
                dout_d[l] = dout_size'((mem_q[rd_bank_q][rd_cnt_q][l] <<< shift_q) >>> DROP);
            end
            if (rd_cnt_q == '0) zcnt_d = bcnt_q[rd_bank_q];
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == BW'(BEATS - 1)) rd_active_d = 1'b0;
        end

        // A newly completed block takes over the read side, even on the edge
        // that emits the final beat of the previous block.
        if (last_beat) begin
            rd_active_d = 1'b1;
            rd_cnt_d    = '0;
            rd_bank_d   = wr_bank_q;
            shift_d     = block_min;
        end
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rstn) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_active_q <= 1'b0;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            shift_q     <= '0;
            valid_q     <= 1'b0;
            for (int l = 0; l < array_size; l++) dout_q[l] <= '0;
            for (int b = 0; b < BEATS; b++)      zcnt_q[b] <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_active_q <= rd_active_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            shift_q     <= shift_d;
            valid_q     <= valid_d;
            dout_q      <= dout_d;
            zcnt_q      <= zcnt_d;
        end
    end

    // Buffer write: store the beat and its count into the current slot
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the read side only ever reads slots written by a completed block.
        if (valid_in) begin
            for (int l = 0; l < array_size; l++) mem_q[wr_bank_q][wr_cnt_q][l] <= din_re_p[l];
            bcnt_q[wr_bank_q][wr_cnt_q] <= beat_cnt;
        end
    end

    assign dout_re_p = dout_q;
    assign valid_out = valid_q;
    assign zero_cnt  = zcnt_q;

endmodule

// File: tb/tb_test_cbfp.sv
// Self-checking bench for test_cbfp: a scoreboard of expected output beats
// (data, counts and arrival cycle) is filled as each block is driven and
// drained by a negedge monitor.
module tb_test_cbfp;

    localparam int CS = 5;
    localparam int AS = 16;
    localparam int DI = 23;
    localparam int DO = 11;
    localparam int BD = 64;
    localparam int NB = BD / AS;

    typedef logic signed [DI-1:0] din_t;
    typedef struct {
        logic [DO*AS-1:0] d;
        logic [CS*NB-1:0] z;
        longint           due;
    } item_t;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 valid_in;
    logic signed [DI-1:0] din  [AS];
    logic signed [DO-1:0] dout [AS];
    logic                 valid_out;
    logic [CS-1:0]        zc   [NB];

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    bit     mon_en   = 1'b0;
    item_t  sb[$];
    item_t  it;
    bit     exp_v;
    din_t   blk [NB][AS];

    test_cbfp #(
        .cnt_size(CS), .array_size(AS), .din_size(DI), .dout_size(DO), .buffer_depth(BD)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .valid_in (valid_in),
        .din_re_p (din),
        .dout_re_p(dout),
        .valid_out(valid_out),
        .zero_cnt (zc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [DO*AS-1:0] pack_d();
        logic [DO*AS-1:0] p;
        for (int l = 0; l < AS; l++) p[l*DO +: DO] = dout[l];
        return p;
    endfunction

    function automatic logic [CS*NB-1:0] pack_z();
        logic [CS*NB-1:0] p;
        for (int b = 0; b < NB; b++) p[b*CS +: CS] = zc[b];
        return p;
    endfunction

    // Reference sign-bit count: scan downward from bit DI-2 until the sign differs
    function automatic int model_cnt(input din_t x);
        int n;
        n = 0;
        for (int i = DI - 2; i >= 0; i--) begin
            if (x[i] != x[DI-1]) break;
            n++;
        end
        return n;
    endfunction

    // Reference output: widen, shift, keep bits [DI-1:DI-DO]
    function automatic logic [DO-1:0] model_out(input din_t x, input int s);
        logic signed [63:0] w;
        w = 64'(x);
        w = w <<< s;
        return w[DI-1:DI-DO];
    endfunction

    task automatic fill(input din_t v);
        for (int b = 0; b < NB; b++)
            for (int l = 0; l < AS; l++) blk[b][l] = v;
    endtask

    // Drive the block in blk with `gap` idle cycles between beats, then queue expectations
    task automatic send_block(input int gap);
        int    bc [NB];
        int    s;
        item_t e;
        for (int b = 0; b < NB; b++) begin
            for (int l = 0; l < AS; l++) din[l] = blk[b][l];
            valid_in = 1'b1;
            @(posedge clk); #1;
            valid_in = 1'b0;
            if (b < NB - 1) repeat (gap) begin @(posedge clk); #1; end
        end
        s = DI - 1;
        for (int b = 0; b < NB; b++) begin
            bc[b] = DI - 1;
            for (int l = 0; l < AS; l++)
                if (model_cnt(blk[b][l]) < bc[b]) bc[b] = model_cnt(blk[b][l]);
            if (bc[b] < s) s = bc[b];
        end
        for (int b = 0; b < NB; b++) begin
            for (int l = 0; l < AS; l++) e.d[l*DO +: DO] = model_out(blk[b][l], s);
            for (int k = 0; k < NB; k++) e.z[k*CS +: CS] = CS'(bc[k]);
            e.due = cyc + 1 + b;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, valid_out, 1'b0);
        check({tag, "_dout"},  pack_d(),  '0);
        check({tag, "_zcnt"},  pack_z(),  '0);
    endtask

    // Monitor: compare against the scoreboard away from the rising edge
    always @(negedge clk) begin
        if (mon_en) begin
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            check("valid_out", valid_out, exp_v);
            if (exp_v) begin
                it = sb.pop_front();
                if (valid_out) begin
                    check("dout", pack_d(), it.d);
                    check("zero_cnt", pack_z(), it.z);
                end
            end else begin
                check("dout_idle", pack_d(), '0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b0;
        valid_in = 1'b0;
        for (int l = 0; l < AS; l++) din[l] = '0;

        // Reset held for 10 cycles, then idle
        @(posedge clk); #1;
        mon_en = 1'b1;
        idle(9);
        check_reset_outputs("reset");
        rstn = 1'b1;
        idle(5);
        check_reset_outputs("post_reset_idle");

        // All ones: count 21, every output 512
        fill(din_t'(1));
        send_block(0);
        idle(6);

        // One max-positive lane in beat 2 forces shift 0
        fill(din_t'(1));
        blk[2][5] = din_t'(4194303);
        send_block(0);
        idle(6);

        // All -4096: count 10, outputs -1024
        fill(din_t'(-4096));
        send_block(0);
        idle(6);

        // All zero: count 22, outputs 0
        fill(din_t'(0));
        send_block(0);
        idle(6);

        // Gapped beats, then a further block after 4 idle cycles
        fill(din_t'(1));
        blk[2][5] = din_t'(4194303);
        send_block(4);
        idle(4);
        send_block(0);
        idle(6);

        // Back-to-back blocks A (all 1) and B (all 256)
        fill(din_t'(1));
        send_block(0);
        fill(din_t'(256));
        send_block(0);
        idle(6);

        // Partial third block discarded by reset
        fill(din_t'(7));
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < AS; l++) din[l] = blk[b][l];
            valid_in = 1'b1;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        rstn     = 1'b0;
        idle(3);
        check_reset_outputs("mid_block_reset");
        rstn = 1'b1;
        idle(20);
        check_reset_outputs("after_discard");

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
